// File: rtl/alu_issue_ctrl.sv
// Issue controller for one ALU: accepts a tagged request, pulses the instruction
// for one cycle, waits out the ALU latency and hands back the captured result.
module alu_issue_ctrl #(
    parameter int DATA_W  = 65,
    parameter int INSTR_W = 33,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1,
    parameter int NOP_OP  = 128,
    parameter int CNT_W   = 16
) (
    input  logic               c,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [INSTR_W-1:0] cmd_op,
    input  logic [DATA_W-1:0]  cmd_a,
    input  logic [DATA_W-1:0]  cmd_b,
    input  logic [TAG_W-1:0]   cmd_tag,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [INSTR_W-1:0] alu_instr,
    input  logic [DATA_W-1:0]  alu_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [CNT_W-1:0]   done_cnt,
    output logic               busy
);

    // A latency below one would leave WAIT with nothing to count, so clamp it.
    localparam int LAT_EFF = (ALU_LAT < 1) ? 1 : ALU_LAT;
    localparam int WCNT_W  = (LAT_EFF < 2) ? 1 : $clog2(LAT_EFF + 1);

    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_OP);
    localparam logic [WCNT_W-1:0]  LAT_INIT  = WCNT_W'(LAT_EFF);
    localparam logic [WCNT_W-1:0]  WCNT_ONE  = WCNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_reg;
    logic [WCNT_W-1:0]    wait_cnt_reg;
    logic [TAG_W-1:0]     tag_reg;
    logic [DATA_W-1:0]    alu_a_reg;
    logic [DATA_W-1:0]    alu_b_reg;
    logic [INSTR_W-1:0]   alu_instr_reg;
    logic                 rsp_valid_reg;
    logic [DATA_W-1:0]    rsp_data_reg;
    logic [TAG_W-1:0]     rsp_tag_reg;
    logic [CNT_W-1:0]     done_cnt_reg;

    always_ff @(posedge c) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            tag_reg       <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_instr_reg <= NOP_INSTR;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_tag_reg   <= '0;
            done_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a_reg     <= cmd_a;
                        alu_b_reg     <= cmd_b;
                        alu_instr_reg <= cmd_op;
                        tag_reg       <= cmd_tag;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The ALU samples the op on this edge; from here on it must see NOP
                    // so its output register holds still until we capture it.
                    alu_instr_reg <= NOP_INSTR;
                    wait_cnt_reg  <= LAT_INIT;
                    state_reg     <= WAIT;
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg - WCNT_ONE;
                    if (wait_cnt_reg == WCNT_ONE) begin
                        rsp_data_reg  <= alu_out;
                        rsp_tag_reg   <= tag_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        done_cnt_reg  <= done_cnt_reg + CNT_ONE;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_instr = alu_instr_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_tag   = rsp_tag_reg;
    assign done_cnt  = done_cnt_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU (op 32 = add,
// registered, NOP holds). Counter width is shrunk to 4 bits to exercise wrap.
module tb_alu_issue_ctrl;

    localparam int DATA_W  = 65;
    localparam int INSTR_W = 33;
    localparam int TAG_W   = 4;
    localparam int CNT_W   = 4;

    logic               c = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [INSTR_W-1:0] cmd_op = '0;
    logic [DATA_W-1:0]  cmd_a = '0;
    logic [DATA_W-1:0]  cmd_b = '0;
    logic [TAG_W-1:0]   cmd_tag = '0;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [INSTR_W-1:0] alu_instr;
    logic [DATA_W-1:0]  alu_out = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [DATA_W-1:0]  rsp_data;
    logic [TAG_W-1:0]   rsp_tag;
    logic [CNT_W-1:0]   done_cnt;
    logic               busy;

    int n_vec  = 0;
    int n_miss = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always #5 c = ~c;

    // Behavioural ALU: registered add, anything else holds the output.
    always @(posedge c) begin
        if (alu_instr == 33'd32)
            alu_out <= alu_a + alu_b;
    end

    alu_issue_ctrl #(
        .DATA_W (DATA_W),
        .INSTR_W(INSTR_W),
        .TAG_W  (TAG_W),
        .ALU_LAT(1),
        .NOP_OP (128),
        .CNT_W  (CNT_W)
    ) dut (
        .c        (c),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_tag  (cmd_tag),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_instr(alu_instr),
        .alu_out  (alu_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_tag  (rsp_tag),
        .done_cnt (done_cnt),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge c);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    // Present a request and return once it has been accepted (state is ISSUE).
    task automatic send_req(input logic [INSTR_W-1:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tg);
        bit accepted;
        accepted = 1'b0;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tg;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = cmd_ready;
            step();
        end
        cmd_valid = 1'b0;
        if (!accepted) chk("accept_timeout", 0, 1);
    endtask

    // Step until rsp_valid is seen (sampled after an edge), bounded.
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rsp_valid) ok = 1'b1;
            else step();
        end
        if (!ok) chk("rsp_timeout", 0, 1);
    endtask

    // Full request with rsp_ready=1; returns after the response handshake edge.
    task automatic full_req(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [TAG_W-1:0] tg, input logic [DATA_W-1:0] exp_data,
                            input string name);
        bit ok;
        rsp_ready = 1'b1;
        send_req(33'd32, a, b, tg);
        wait_rsp(ok);
        if (ok) begin
            chk({name, "_data"}, rsp_data, exp_data);
            chk({name, "_tag"}, rsp_tag, tg);
            step();
            exp_cnt = exp_cnt + 1'b1;
            chk({name, "_cnt"}, done_cnt, exp_cnt);
            $display("txn %s tag=%0d data=%0h cnt=%0d", name, rsp_tag, rsp_data, done_cnt);
        end
    endtask

    initial begin
        bit ok;
        int sent, got, cyc, last_hs;
        logic acc, hs;

        // Reset state
        do_reset();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_alu_instr", alu_instr, 128);
        chk("rst_alu_a", alu_a, 0);

        // Single add, cycle by cycle
        rsp_ready = 1'b1;
        cmd_op = 33'd32; cmd_a = 65'd5; cmd_b = 65'd7; cmd_tag = 4'd3; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("t1_issue_instr", alu_instr, 32);
        chk("t1_issue_a", alu_a, 5);
        chk("t1_issue_b", alu_b, 7);
        chk("t1_issue_ready", cmd_ready, 0);
        chk("t1_issue_busy", busy, 1);
        step();
        chk("t1_wait_instr", alu_instr, 128);
        chk("t1_wait_valid", rsp_valid, 0);
        step();
        chk("t1_resp_valid", rsp_valid, 1);
        chk("t1_resp_data", rsp_data, 12);
        chk("t1_resp_tag", rsp_tag, 3);
        chk("t1_resp_instr", alu_instr, 128);
        step();
        exp_cnt = 4'd1;
        chk("t1_idle_valid", rsp_valid, 0);
        chk("t1_idle_cnt", done_cnt, exp_cnt);
        chk("t1_idle_ready", cmd_ready, 1);
        chk("t1_idle_instr", alu_instr, 128);
        chk("t1_idle_data_held", rsp_data, 12);
        $display("txn t1 tag=%0d data=%0h cnt=%0d", rsp_tag, rsp_data, done_cnt);

        // Back-pressure: rsp_ready low for 10 cycles
        rsp_ready = 1'b0;
        send_req(33'd32, 65'd20, 65'd22, 4'd9);
        wait_rsp(ok);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 42);
            chk("bp_tag", rsp_tag, 9);
            chk("bp_ready", cmd_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        exp_cnt = exp_cnt + 1'b1;
        chk("bp_rel_valid", rsp_valid, 0);
        chk("bp_rel_ready", cmd_ready, 1);
        chk("bp_rel_cnt", done_cnt, exp_cnt);
        $display("txn bp tag=%0d data=%0h cnt=%0d", rsp_tag, rsp_data, done_cnt);

        // Back-to-back with cmd_valid held high
        sent = 0; got = 0; cyc = 0; last_hs = -1;
        cmd_op = 33'd32; cmd_a = 65'd0; cmd_b = 65'd100; cmd_tag = 4'd0; cmd_valid = 1'b1;
        while (got < 8 && cyc < 200) begin
            acc = cmd_valid && cmd_ready;
            hs  = rsp_valid && rsp_ready;
            if (hs) begin
                chk("b2b_data", rsp_data, 100 + got);
                chk("b2b_tag", rsp_tag, got);
                if (last_hs >= 0) chk("b2b_spacing", cyc - last_hs, 4);
                $display("txn b2b tag=%0d data=%0h cyc=%0d", rsp_tag, rsp_data, cyc);
                last_hs = cyc;
                got++;
            end
            step();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 8) begin
                    cmd_a = 65'(sent); cmd_tag = 4'(sent);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        chk("b2b_count", got, 8);
        exp_cnt = exp_cnt + 4'd8;
        chk("b2b_done_cnt", done_cnt, exp_cnt);

        // Reset during WAIT drops the request
        send_req(33'd32, 65'd1, 65'd2, 4'd6);
        step();
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_cnt = '0;
        chk("mid_ready", cmd_ready, 1);
        chk("mid_valid", rsp_valid, 0);
        chk("mid_instr", alu_instr, 128);
        chk("mid_cnt", done_cnt, 0);
        chk("mid_data", rsp_data, 0);
        for (int i = 0; i < 6; i++) begin
            chk("mid_no_stale", rsp_valid, 0);
            step();
        end
        $display("txn mid_reset cnt=%0d", done_cnt);

        // 65-bit overflow passes through untouched
        full_req({DATA_W{1'b1}}, 65'd1, 4'd12, 65'd0, "ovf");

        // Counter wrap: 17 requests from reset
        do_reset();
        for (int i = 0; i < 17; i++)
            full_req(65'(i), 65'd1, 4'(i), 65'(i + 1), "wrap");
        chk("wrap_final", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
